// File: rtl/map_table_ckpt.sv
// Rename map table with branch checkpoints.
// Maps architectural source registers to producer RS tags for a superscalar dispatch bundle,
// clears entries as tags complete on the CDB, and keeps a circular set of snapshots so a
// mispredicted branch can roll the table back in a single cycle. Tag 0 means "value in RF".
module map_table_ckpt #(
    parameter int NUM_REGS   = 32,
    parameter int TAG_W      = 5,
    parameter int DISPATCH_W = 2,
    parameter int CDB_W      = 2,
    parameter int NUM_CKPT   = 4,
    localparam int REG_W     = $clog2(NUM_REGS),
    localparam int CKPT_W    = $clog2(NUM_CKPT),
    localparam int CNT_W     = $clog2(NUM_CKPT + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DISPATCH_W-1:0]       disp_valid,
    input  logic [DISPATCH_W-1:0]       disp_rd_valid,
    input  logic [DISPATCH_W*REG_W-1:0] disp_rd_idx,
    input  logic [DISPATCH_W*TAG_W-1:0] disp_tag,
    input  logic [DISPATCH_W-1:0]       rs1_valid,
    input  logic [DISPATCH_W-1:0]       rs2_valid,
    input  logic [DISPATCH_W*REG_W-1:0] rs1_idx,
    input  logic [DISPATCH_W*REG_W-1:0] rs2_idx,
    output logic [DISPATCH_W*TAG_W-1:0] rs1_tag,
    output logic [DISPATCH_W*TAG_W-1:0] rs2_tag,
    input  logic [CDB_W-1:0]            cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]      cdb_tag,
    input  logic                        ckpt_req,
    output logic [CKPT_W-1:0]           ckpt_id,
    output logic                        disp_ready,
    input  logic                        restore_valid,
    input  logic [CKPT_W-1:0]           restore_id,
    input  logic                        release_valid
);

    logic [TAG_W-1:0]  map_q   [NUM_REGS];
    logic [TAG_W-1:0]  snap_q  [NUM_CKPT][NUM_REGS];
    logic [TAG_W-1:0]  map_clr [NUM_REGS];
    logic [TAG_W-1:0]  map_nxt [NUM_REGS];
    logic [CKPT_W-1:0] head_q;
    logic [CKPT_W-1:0] tail_q;
    logic [CKPT_W-1:0] head_rel;
    logic [CKPT_W-1:0] restore_dist;
    logic [CNT_W-1:0]  count_q;
    logic              ckpt_acc;
    logic              disp_acc;
    logic              rel_acc;

    // True when a nonzero tag is being broadcast on any valid CDB port this cycle.
    function automatic logic cdb_hit(input logic [TAG_W-1:0]       tag,
                                     input logic [CDB_W-1:0]       valid,
                                     input logic [CDB_W*TAG_W-1:0] tags);
        cdb_hit = 1'b0;
        for (int k = 0; k < CDB_W; k++) begin
            if (valid[k] && (tag != '0) && (tags[k*TAG_W +: TAG_W] == tag)) begin
                cdb_hit = 1'b1;
            end
        end
    endfunction

    // A full checkpoint ring stalls branch bundles; a restore squashes the whole bundle.
    assign disp_ready   = (count_q != CNT_W'(NUM_CKPT));
    assign ckpt_id      = tail_q;
    assign ckpt_acc     = ckpt_req && disp_ready && !restore_valid;
    assign disp_acc     = !restore_valid && !(ckpt_req && !disp_ready);
    assign rel_acc      = release_valid && (count_q != '0);
    assign head_rel     = head_q + CKPT_W'(rel_acc);
    assign restore_dist = restore_id - head_rel;

    // Table contents with this cycle's completing tags already marked ready.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            map_clr[r] = cdb_hit(map_q[r], cdb_valid, cdb_tag) ? '0 : map_q[r];
        end
    end

    // Next table state: either the restored snapshot or the cleared table plus dispatch writes.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            map_nxt[r] = map_clr[r];
        end
        if (restore_valid) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                map_nxt[r] = cdb_hit(snap_q[restore_id][r], cdb_valid, cdb_tag) ?
                             '0 : snap_q[restore_id][r];
            end
        end else if (disp_acc) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (disp_valid[i] && disp_rd_valid[i] &&
                    (disp_rd_idx[i*REG_W +: REG_W] != '0)) begin
                    map_nxt[disp_rd_idx[i*REG_W +: REG_W]] = disp_tag[i*TAG_W +: TAG_W];
                end
            end
        end
    end

    // Source lookup: older lanes in the bundle forward first, then the CDB-bypassed table.
    always_comb begin
        logic             src_v;
        logic [REG_W-1:0] src_idx;
        logic [TAG_W-1:0] tag;
        src_v   = 1'b0;
        src_idx = '0;
        tag     = '0;
        rs1_tag = '0;
        rs2_tag = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            for (int s = 0; s < 2; s++) begin
                src_v   = (s == 0) ? rs1_valid[i] : rs2_valid[i];
                src_idx = (s == 0) ? rs1_idx[i*REG_W +: REG_W] : rs2_idx[i*REG_W +: REG_W];
                tag     = '0;
                if (src_v && (src_idx != '0)) begin
                    tag = map_clr[src_idx];
                    for (int j = 0; j < i; j++) begin
                        if (disp_valid[j] && disp_rd_valid[j] &&
                            (disp_rd_idx[j*REG_W +: REG_W] == src_idx)) begin
                            tag = disp_tag[j*TAG_W +: TAG_W];
                        end
                    end
                end
                if (s == 0) begin
                    rs1_tag[i*TAG_W +: TAG_W] = tag;
                end else begin
                    rs2_tag[i*TAG_W +: TAG_W] = tag;
                end
            end
        end
    end

    // Architectural map registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                map_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                map_q[r] <= map_nxt[r];
            end
        end
    end

    // Snapshots track completions; the tail slot captures the post-update table on a checkpoint.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CKPT; c++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    snap_q[c][r] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CKPT; c++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (ckpt_acc && (tail_q == CKPT_W'(c))) begin
                        snap_q[c][r] <= map_nxt[r];
                    end else if (cdb_hit(snap_q[c][r], cdb_valid, cdb_tag)) begin
                        snap_q[c][r] <= '0;
                    end
                end
            end
        end
    end

    // Checkpoint ring pointers; a restore discards every slot younger than the restored one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q <= head_rel;
            if (restore_valid) begin
                tail_q  <= restore_id + CKPT_W'(1);
                count_q <= CNT_W'(restore_dist) + CNT_W'(1);
            end else begin
                tail_q  <= tail_q + CKPT_W'(ckpt_acc);
                count_q <= count_q + CNT_W'(ckpt_acc) - CNT_W'(rel_acc);
            end
        end
    end

endmodule

// File: tb/tb_map_table_ckpt.sv
// Testbench for map_table_ckpt: directed vector table followed by randomized traffic
// checked against a register-array / live-list reference model.
module tb_map_table_ckpt;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      disp_valid, disp_rd_valid, rs1_valid, rs2_valid, cdb_valid;
    logic [1:0][4:0] disp_rd_idx, disp_tag, rs1_idx, rs2_idx, rs1_tag, rs2_tag, cdb_tag;
    logic            ckpt_req, restore_valid, release_valid, disp_ready;
    logic [1:0]      ckpt_id, restore_id;

    map_table_ckpt dut (
        .clock         (clock),
        .reset         (reset),
        .disp_valid    (disp_valid),
        .disp_rd_valid (disp_rd_valid),
        .disp_rd_idx   (disp_rd_idx),
        .disp_tag      (disp_tag),
        .rs1_valid     (rs1_valid),
        .rs2_valid     (rs2_valid),
        .rs1_idx       (rs1_idx),
        .rs2_idx       (rs2_idx),
        .rs1_tag       (rs1_tag),
        .rs2_tag       (rs2_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .ckpt_req      (ckpt_req),
        .ckpt_id       (ckpt_id),
        .disp_ready    (disp_ready),
        .restore_valid (restore_valid),
        .restore_id    (restore_id),
        .release_valid (release_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]      dv, rdv, v1, v2, cv;
        logic [1:0][4:0] rd, tg, r1, r2, ct;
        logic            ck, rs, rl;
        logic [1:0]      rid;
    } stim_t;

    typedef struct {
        stim_t s;
        int    e10, e11, e20, e21, eid, erdy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: flat register map, one snapshot array per slot, list of live slot ids.
    int mmap[32];
    int msnap[4][32];
    int live[$];
    int mtail;

    function automatic stim_t idle();
        stim_t s;
        s.dv = '0; s.rdv = '0; s.v1 = '0; s.v2 = '0; s.cv = '0;
        s.rd = '0; s.tg = '0; s.r1 = '0; s.r2 = '0; s.ct = '0;
        s.ck = 1'b0; s.rs = 1'b0; s.rl = 1'b0; s.rid = '0;
        return s;
    endfunction

    function automatic stim_t wr(stim_t s, int lane, int rd, int tag);
        s.dv[lane] = 1'b1; s.rdv[lane] = 1'b1; s.rd[lane] = 5'(rd); s.tg[lane] = 5'(tag);
        return s;
    endfunction

    function automatic stim_t rd1(stim_t s, int lane, int idx);
        s.v1[lane] = 1'b1; s.r1[lane] = 5'(idx);
        return s;
    endfunction

    function automatic stim_t rd2(stim_t s, int lane, int idx);
        s.v2[lane] = 1'b1; s.r2[lane] = 5'(idx);
        return s;
    endfunction

    function automatic stim_t cdb(stim_t s, int port, int tag);
        s.cv[port] = 1'b1; s.ct[port] = 5'(tag);
        return s;
    endfunction

    function automatic stim_t ck(stim_t s);
        s.ck = 1'b1;
        return s;
    endfunction

    function automatic stim_t rl(stim_t s);
        s.rl = 1'b1;
        return s;
    endfunction

    function automatic stim_t rsr(stim_t s, int id);
        s.rs = 1'b1; s.rid = 2'(id);
        return s;
    endfunction

    function automatic void addVec(stim_t s, int e10, int e11, int e20, int e21, int eid, int erdy);
        vec_t v;
        v.s = s; v.e10 = e10; v.e11 = e11; v.e20 = e20; v.e21 = e21; v.eid = eid; v.erdy = erdy;
        vecs.push_back(v);
    endfunction

    function automatic bit cdbHitM(stim_t s, int t);
        if (t == 0) return 1'b0;
        for (int k = 0; k < 2; k++) if (s.cv[k] && (int'(s.ct[k]) == t)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mLookup(stim_t s, int lane, int which);
        logic v;
        int   idx;
        v   = (which == 1) ? s.v1[lane] : s.v2[lane];
        idx = (which == 1) ? int'(s.r1[lane]) : int'(s.r2[lane]);
        if (!v || idx == 0) return 0;
        for (int j = lane - 1; j >= 0; j--) begin
            if (s.dv[j] && s.rdv[j] && int'(s.rd[j]) == idx) return int'(s.tg[j]);
        end
        if (cdbHitM(s, mmap[idx])) return 0;
        return mmap[idx];
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 32; r++) mmap[r] = 0;
        live.delete();
        mtail = 0;
    endtask

    task automatic modelStep(stim_t s);
        bit rel;
        bit found;
        rel = s.rl && (live.size() > 0);
        for (int r = 0; r < 32; r++) begin
            if (cdbHitM(s, mmap[r])) mmap[r] = 0;
            for (int c = 0; c < 4; c++) if (cdbHitM(s, msnap[c][r])) msnap[c][r] = 0;
        end
        if (s.rs) begin
            if (rel) void'(live.pop_front());
            found = 1'b0;
            foreach (live[q]) if (live[q] == int'(s.rid)) found = 1'b1;
            assert (found) else $error("[TB] restore requested for slot %0d which is not live", s.rid);
            while (live.size() > 0 && live[live.size()-1] != int'(s.rid)) void'(live.pop_back());
            for (int r = 0; r < 32; r++) mmap[r] = msnap[s.rid][r];
            mtail = (int'(s.rid) + 1) % 4;
        end else begin
            if (!(s.ck && live.size() == 4)) begin
                for (int i = 0; i < 2; i++) begin
                    if (s.dv[i] && s.rdv[i] && s.rd[i] != 0) mmap[s.rd[i]] = int'(s.tg[i]);
                end
            end
            if (s.ck && live.size() < 4) begin
                for (int r = 0; r < 32; r++) msnap[mtail][r] = mmap[r];
                live.push_back(mtail);
                mtail = (mtail + 1) % 4;
            end
            if (rel) void'(live.pop_front());
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(stim_t s);
        disp_valid = s.dv; disp_rd_valid = s.rdv; disp_rd_idx = s.rd; disp_tag = s.tg;
        rs1_valid = s.v1; rs2_valid = s.v2; rs1_idx = s.r1; rs2_idx = s.r2;
        cdb_valid = s.cv; cdb_tag = s.ct;
        ckpt_req = s.ck; restore_valid = s.rs; restore_id = s.rid; release_valid = s.rl;
    endtask

    task automatic applyStimulus(stim_t s);
        @(negedge clock);
        drive(s);
        #1;
    endtask

    task automatic checkAll(string n, int e10, int e11, int e20, int e21, int eid, int erdy);
        checkOutput({n, " rs1_tag[0]"}, 32'(rs1_tag[0]), 32'(e10));
        checkOutput({n, " rs1_tag[1]"}, 32'(rs1_tag[1]), 32'(e11));
        checkOutput({n, " rs2_tag[0]"}, 32'(rs2_tag[0]), 32'(e20));
        checkOutput({n, " rs2_tag[1]"}, 32'(rs2_tag[1]), 32'(e21));
        checkOutput({n, " ckpt_id"}, 32'(ckpt_id), 32'(eid));
        checkOutput({n, " disp_ready"}, 32'(disp_ready), 32'(erdy));
    endtask

    task automatic runModelCycle(stim_t s, string n);
        applyStimulus(s);
        checkAll(n, mLookup(s, 0, 1), mLookup(s, 1, 1), mLookup(s, 0, 2), mLookup(s, 1, 2),
                 mtail, (live.size() != 4) ? 1 : 0);
        modelStep(s);
    endtask

    function automatic stim_t randStim();
        stim_t s;
        int    lo;
        s = idle();
        s.dv = 2'($urandom_range(0, 3));
        s.rdv = 2'($urandom_range(0, 3));
        s.v1 = 2'($urandom_range(0, 3));
        s.v2 = 2'($urandom_range(0, 3));
        s.cv = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2; i++) begin
            s.rd[i] = 5'($urandom_range(0, 7));
            s.tg[i] = 5'($urandom_range(1, 31));
            s.r1[i] = 5'($urandom_range(0, 7));
            s.r2[i] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) s.ct[i] = 5'(mmap[$urandom_range(1, 7)]);
            else                           s.ct[i] = 5'($urandom_range(0, 31));
        end
        s.ck = ($urandom_range(0, 3) == 0);
        s.rl = ($urandom_range(0, 5) == 0);
        if (live.size() > 0 && $urandom_range(0, 9) == 0) begin
            s.rs = 1'b1;
            if (s.rl && live.size() < 2) s.rl = 1'b0;
            lo = s.rl ? 1 : 0;
            s.rid = 2'(live[$urandom_range(lo, live.size() - 1)]);
        end
        return s;
    endfunction

    initial begin
        stim_t s;
        drive(idle());
        modelReset();

        // Directed vectors; expected values derived by hand from the block's rules.
        addVec(rd1(rd1(wr(idle(), 0, 5, 3), 1, 5), 0, 5),           0, 3, 0, 0, 0, 1);
        addVec(rd1(rd1(idle(), 0, 5), 1, 5),                        3, 3, 0, 0, 0, 1);
        addVec(rd1(wr(idle(), 0, 7, 4), 1, 7),                      0, 4, 0, 0, 0, 1);
        addVec(rd1(rd1(cdb(idle(), 0, 4), 0, 7), 1, 5),             0, 3, 0, 0, 0, 1);
        addVec(rd2(rd1(idle(), 0, 7), 0, 5),                        0, 0, 3, 0, 0, 1);
        addVec(rd1(cdb(wr(wr(idle(), 0, 9, 2), 1, 9, 6), 1, 2), 1, 9), 0, 2, 0, 0, 0, 1);
        addVec(rd2(rd1(idle(), 0, 9), 1, 9),                        6, 0, 0, 6, 0, 1);
        addVec(rd1(ck(wr(idle(), 0, 1, 2)), 1, 1),                  0, 2, 0, 0, 0, 1);
        addVec(rd2(rd1(wr(idle(), 0, 1, 5), 1, 1), 0, 9),           0, 5, 6, 0, 1, 1);
        addVec(rd1(wr(rsr(cdb(idle(), 0, 2), 0), 0, 3, 7), 0, 1),   5, 0, 0, 0, 1, 1);
        addVec(rd2(rd2(rd1(rd1(idle(), 0, 1), 1, 3), 0, 9), 1, 5),  0, 0, 6, 3, 1, 1);
        addVec(ck(idle()),                                          0, 0, 0, 0, 1, 1);
        addVec(ck(idle()),                                          0, 0, 0, 0, 2, 1);
        addVec(ck(idle()),                                          0, 0, 0, 0, 3, 1);
        addVec(ck(wr(idle(), 0, 3, 8)),                             0, 0, 0, 0, 0, 0);
        addVec(rd1(rl(idle()), 0, 3),                               0, 0, 0, 0, 0, 0);
        addVec(rd1(rd1(idle(), 0, 5), 1, 9),                        3, 6, 0, 0, 0, 1);

        // Reset state, observed while reset is still held.
        @(negedge clock);
        drive(rd2(rd1(rd1(idle(), 0, 5), 1, 9), 0, 1));
        #1;
        checkAll("reset", 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].s);
            checkAll($sformatf("vec%0d", n), vecs[n].e10, vecs[n].e11, vecs[n].e20,
                     vecs[n].e21, vecs[n].eid, vecs[n].erdy);
            modelStep(vecs[n].s);
        end

        for (int c = 0; c < 3000; c++) begin
            runModelCycle(randStim(), $sformatf("rand%0d", c));
        end

        // Asynchronous reset in mid-cycle must clear everything without a clock edge.
        runModelCycle(wr(wr(idle(), 0, 2, 9), 1, 3, 10), "prewrite");
        s = rd2(rd2(rd1(rd1(idle(), 0, 2), 1, 3), 0, 3), 1, 2);
        applyStimulus(s);
        checkAll("prereset", 9, 10, 10, 9, mtail, (live.size() != 4) ? 1 : 0);
        #1 reset = 1'b0;
        #1;
        checkAll("midreset", 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        reset = 1'b1;
        modelReset();
        runModelCycle(s, "postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
